axis_frame_reader: RTL



---
 rtl/axis_frame_reader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_reader.sv
// AXI4-Stream frame reader: streams whole frames from a 1-cycle-latency word store, start to first tvalid 3 cycles, 1 beat/cycle.
// Reads are throttled so at most 2 beats are buffered or in flight; optional pixel reversal under AXIS_READER_PIXEL_SWAP_EN.

// Generic synchronous FIFO; head visible combinationally, push into a full FIFO is the caller's responsibility to avoid.
module axis_frame_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    entries [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic                do_pop;

    assign do_pop = pop && (count != '0);
    assign dout   = entries[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr] <= din;
                wr_ptr <= (wr_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr + PTR_BITS'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module axis_frame_reader #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int N_IMAGES        = 50,
    parameter int WORD_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT,
    parameter int WORDS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    parameter int MEM_BITS        = $clog2(N_IMAGES * WORDS_PER_IMAGE)
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic                  start,
    input  logic [15:0]           first_frame,
    input  logic [15:0]           num_frames,
    output logic                  mem_rd_en,
    output logic [MEM_BITS-1:0]   mem_rd_addr,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic [WORD_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);
    localparam int                   BEAT_BITS = (WORDS_PER_IMAGE > 1) ? $clog2(WORDS_PER_IMAGE) : 1;
    localparam logic [63:0]          WPI64     = 64'(WORDS_PER_IMAGE);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_IMAGE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           first_q;
    logic [15:0]           num_q;
    logic [15:0]           frame_cnt;
    logic [BEAT_BITS-1:0]  beat_cnt;
    logic                  rd_inflight;
    logic                  rd_inflight_last;
    logic [1:0]            occupancy;
    logic                  pop;
    logic                  start_ok;
    logic                  last_beat;
    logic                  final_issue;
    logic                  issue_ok;
    logic [2:0]            committed;
    logic [WORD_WIDTH-1:0] capture_word;
    logic [WORD_WIDTH:0]   fifo_dout;

    assign start_ok    = (state == S_IDLE) && start;
    assign pop         = m_axis_tvalid && m_axis_tready;
    // A pop this cycle frees its slot before the new read's data can land, keeping 1 beat/cycle.
    assign committed   = {1'b0, occupancy} + {2'b00, rd_inflight} - {2'b00, pop};
    assign issue_ok    = committed < 3'd2;
    assign last_beat   = beat_cnt == LAST_BEAT;
    assign final_issue = mem_rd_en && last_beat && (frame_cnt == num_q - 16'd1);
    assign mem_rd_addr = MEM_BITS'((64'(first_q) + 64'(frame_cnt)) * WPI64 + 64'(beat_cnt));

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_frames == 16'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (final_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish as the last beat leaves so done lands the cycle after its handshake.
                if (!rd_inflight && ((occupancy == 2'd0) || (occupancy == 2'd1 && pop))) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (state == S_FETCH) && issue_ok;
        done      = (state == S_FIN);
        busy      = (state != S_IDLE) || start_ok;
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            first_q   <= '0;
            num_q     <= '0;
            frame_cnt <= '0;
            beat_cnt  <= '0;
        end else if (start_ok) begin
            first_q   <= first_frame;
            num_q     <= num_frames;
            frame_cnt <= '0;
            beat_cnt  <= '0;
        end else if (mem_rd_en) begin
            if (last_beat) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                beat_cnt  <= beat_cnt + BEAT_BITS'(1);
            end
        end
    end

    // tlast rides alongside the read so it stays aligned with its data word.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            rd_inflight      <= mem_rd_en;
            rd_inflight_last <= mem_rd_en && last_beat;
        end
    end

`ifdef AXIS_READER_PIXEL_SWAP_EN
    always_comb begin
        capture_word = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            capture_word[j*PIXEL_WIDTH +: PIXEL_WIDTH] =
                mem_rd_data[(PIXELS_PER_BEAT-1-j)*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end
`else
    assign capture_word = mem_rd_data;
`endif

    axis_frame_reader_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (2)
    ) u_out_fifo (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .push  (rd_inflight),
        .din   ({rd_inflight_last, capture_word}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (occupancy)
    );

    assign m_axis_tvalid = occupancy != 2'd0;
    assign m_axis_tlast  = fifo_dout[WORD_WIDTH];
    assign m_axis_tdata  = fifo_dout[WORD_WIDTH-1:0];
endmodule
